cipher_collector: RTL and testbench
===================================

Name: cipher_collector

Overview:
- Downstream of the ASCON control FSM and datapath.
- Captures the four 64-bit ciphertext blocks, each marked by a one-cycle cipher_valid pulse, and the final 128-bit tag, marked by the end pulse.
- Presents the assembled ciphertext and tag as one registered result.
- Hands the result to the consumer (testbench or output interface) with a valid/ready handshake.

Parameters:
- BLOCK_W, 64, width of one ciphertext block.
- NB_BLOCKS, 4, number of ciphertext blocks per message.
- TAG_W, 128, tag width.

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  new message; clears buffer, count and flags.
- cipher_valid_i  in  1  one-cycle strobe: cipher_i holds a valid block.
- cipher_i  in  BLOCK_W  ciphertext block.
- tag_valid_i  in  1  one-cycle strobe: tag_i holds the final tag.
- tag_i  in  TAG_W  authentication tag.
- ready_i  in  1  consumer accepts the result.
- cipher_o  out  BLOCK_W*NB_BLOCKS  assembled ciphertext; block 0 in the MSBs.
- tag_o  out  TAG_W  captured tag.
- valid_o  out  1  result available.
- count_o  out  3  number of blocks captured so far.
- busy_o  out  1  a message is being collected.
- error_o  out  1  sticky protocol error.

Behaviour:
Reset:
- Asynchronous on reset_i=1. State=IDLE.
- cipher_o=0, tag_o=0, count_o=0, valid_o=0, busy_o=0, error_o=0.
- Reset mid-message discards everything.

State machine (collect_state_t):
- IDLE:
  - start_i -> COLLECT, count=0, buffer=0, error=0.
  - Strobes (cipher_valid_i, tag_valid_i) in IDLE are ignored and set error_o.
- COLLECT:
  - On cipher_valid_i: write cipher_i into slot count. Slot k occupies bits [(NB_BLOCKS-k)*BLOCK_W-1 -: BLOCK_W]. Then count+1.
  - On the block that makes count=NB_BLOCKS -> WAIT_TAG.
  - tag_valid_i alone before NB_BLOCKS blocks: capture the tag, set error_o, -> DONE. count_o keeps the partial count.
  - cipher_valid_i and tag_valid_i in the same cycle: the block is captured first, then the tag.
    - If this is the last block -> DONE, no error.
    - If not the last block -> DONE with error_o=1.
- WAIT_TAG:
  - tag_valid_i -> capture tag_i, -> DONE.
  - cipher_valid_i here: block dropped, error_o=1 (overflow), count saturates at NB_BLOCKS.
- DONE:
  - valid_o=1. cipher_o and tag_o are held stable.
  - ready_i=1 -> IDLE; valid_o is 0 the next cycle.
  - ready_i=1 and start_i=1 together -> COLLECT directly (back-to-back message). Buffer and count are cleared in the same edge.
  - start_i without ready_i is ignored; no result loss.
  - Strobes in DONE set error_o; data is not overwritten.

Restart and status outputs:
- start_i in COLLECT or WAIT_TAG: restart. Clear buffer, count and error; stay/go COLLECT.
- busy_o=1 in COLLECT and WAIT_TAG.

Timing:
- All outputs are registered; no combinational path input->output.
- Latency: valid_o rises the cycle after the edge that samples tag_valid_i.
- cipher_o bits are updated on the edge that samples each strobe.

Width rules:
- count_o is 3 bits and holds 0..NB_BLOCKS; it never wraps.
- NB_BLOCKS must be ≤7.

Decomposition:
- ascon_pack gains:
  - typedef enum collect_state_t {IDLE, COLLECT, WAIT_TAG, DONE}.
  - Constants CIPHER_BLOCK_W=64, CIPHER_NB_BLOCKS=4, TAG_W=128, used as the parameter defaults.
- No sub-module. Buffer write, counter and FSM live in one module: a sequential state/data process plus a combinational next-state process.

Test Plan:
1. Nominal: reset, start_i. Send 4 strobes with cipher_i = 64'h1111..., 64'h2222..., 64'h3333..., 64'h4444... separated by wait gaps. Then send tag_i=128'hDEAD_BEEF_...
   -> cipher_o=256'h1111...2222...3333...4444..., tag_o correct, valid_o=1 one cycle after the tag, error_o=0, count_o=4.
2. Handshake: hold ready_i=0 for 5 cycles -> outputs stable, valid_o held. Then ready_i=1 -> valid_o=0 the next cycle, state IDLE.
3. Early tag: 2 blocks, then tag_valid_i -> valid_o=1, count_o=2, error_o=1. Slots 2-3 remain 0.
4. Overflow: 4 blocks plus a 5th block 64'hFFFF... before the tag -> error_o=1, cipher_o unchanged, count_o=4. The tag still completes the message.
5. Simultaneous: last block and tag strobed in the same cycle -> both captured, valid_o=1, error_o=0. Then start_i+ready_i together -> COLLECT, count_o=0, buffer cleared.
6. Reset mid-message: assert reset_i asynchronously (off clock edge) after 2 blocks -> all outputs 0 immediately. Then a fresh 4-block message is collected correctly.

Source files
------------

// File: rtl/cipher_collector_pkg.sv
// ============================================================================
// Module   : cipher_collector_pkg
// Brief    : Shared sizes and FSM state type for the ciphertext/tag collector.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cipher_collector_pkg;

    localparam int CIPHER_BLOCK_W   = 64;
    localparam int CIPHER_NB_BLOCKS = 4;
    localparam int TAG_W            = 128;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        WAIT_TAG = 2'd2,
        DONE     = 2'd3
    } collect_state_t;

endpackage

`default_nettype wire

// File: rtl/cipher_collector_if.sv
// ============================================================================
// Module   : cipher_collector_if
// Brief    : Strobe inputs and result/handshake outputs of the collector.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface cipher_collector_if #(
    parameter int BLOCK_W   = cipher_collector_pkg::CIPHER_BLOCK_W,
    parameter int NB_BLOCKS = cipher_collector_pkg::CIPHER_NB_BLOCKS,
    parameter int TAG_W     = cipher_collector_pkg::TAG_W
);

    logic                           start_i;
    logic                           cipher_valid_i;
    logic [BLOCK_W-1:0]             cipher_i;
    logic                           tag_valid_i;
    logic [TAG_W-1:0]               tag_i;
    logic                           ready_i;
    logic [BLOCK_W*NB_BLOCKS-1:0]   cipher_o;
    logic [TAG_W-1:0]               tag_o;
    logic                           valid_o;
    logic [2:0]                     count_o;
    logic                           busy_o;
    logic                           error_o;

    modport master (
        output start_i, cipher_valid_i, cipher_i, tag_valid_i, tag_i, ready_i,
        input  cipher_o, tag_o, valid_o, count_o, busy_o, error_o
    );

    modport slave (
        input  start_i, cipher_valid_i, cipher_i, tag_valid_i, tag_i, ready_i,
        output cipher_o, tag_o, valid_o, count_o, busy_o, error_o
    );

endinterface

`default_nettype wire

// File: rtl/cipher_collector.sv
// ============================================================================
// Module   : cipher_collector
// Brief    : Gathers NB_BLOCKS ciphertext blocks plus the tag into one
//            registered result and offers it with a valid/ready handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cipher_collector #(
    parameter int BLOCK_W   = cipher_collector_pkg::CIPHER_BLOCK_W,
    parameter int NB_BLOCKS = cipher_collector_pkg::CIPHER_NB_BLOCKS,
    parameter int TAG_W     = cipher_collector_pkg::TAG_W
) (
    input  wire logic        clock_i,
    input  wire logic        reset_i,
    cipher_collector_if.slave bus
);

    import cipher_collector_pkg::*;

    localparam int         CIPHER_W = BLOCK_W * NB_BLOCKS;
    localparam logic [2:0] NB_CNT   = 3'(NB_BLOCKS);

    collect_state_t         state_q, state_d;
    logic [2:0]             count_q, count_d;
    logic [CIPHER_W-1:0]    buf_q,   buf_d;
    logic [TAG_W-1:0]       tag_q,   tag_d;
    logic                   error_q, error_d;
    logic                   clear_msg;
    logic                   last_blk;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            count_q <= '0;
            buf_q   <= '0;
            tag_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            buf_q   <= buf_d;
            tag_q   <= tag_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        buf_d     = buf_q;
        tag_d     = tag_q;
        error_d   = error_q;
        last_blk  = (count_q + 3'd1) == NB_CNT;
        // In DONE a start only counts when the result is consumed in the same cycle.
        clear_msg = bus.start_i && ((state_q != DONE) || bus.ready_i);

        case (state_q)
            IDLE: begin
                if (bus.cipher_valid_i || bus.tag_valid_i) error_d = 1'b1;
            end
            COLLECT: begin
                if (bus.cipher_valid_i) begin
                    for (int k = 0; k < NB_BLOCKS; k++) begin
                        if (count_q == 3'(k))
                            buf_d[(NB_BLOCKS-k)*BLOCK_W-1 -: BLOCK_W] = bus.cipher_i;
                    end
                    count_d = count_q + 3'd1;
                end
                if (bus.tag_valid_i) begin
                    tag_d   = bus.tag_i;
                    state_d = DONE;
                    if (!(bus.cipher_valid_i && last_blk)) error_d = 1'b1;
                end else if (bus.cipher_valid_i && last_blk) begin
                    state_d = WAIT_TAG;
                end
            end
            WAIT_TAG: begin
                if (bus.cipher_valid_i) error_d = 1'b1;
                if (bus.tag_valid_i) begin
                    tag_d   = bus.tag_i;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.cipher_valid_i || bus.tag_valid_i) error_d = 1'b1;
                if (bus.ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (clear_msg) begin
            state_d = COLLECT;
            count_d = '0;
            buf_d   = '0;
            tag_d   = '0;
            error_d = 1'b0;
        end
    end

    assign bus.cipher_o = buf_q;
    assign bus.tag_o    = tag_q;
    assign bus.count_o  = count_q;
    assign bus.error_o  = error_q;
    assign bus.valid_o  = (state_q == DONE);
    assign bus.busy_o   = (state_q == COLLECT) || (state_q == WAIT_TAG);

endmodule

`default_nettype wire

// File: tb/tb_cipher_collector.sv
// ============================================================================
// Module   : tb_cipher_collector
// Brief    : Self-checking bench for cipher_collector.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cipher_collector;

    localparam int BW = 64;
    localparam int NB = 4;
    localparam int TW = 128;
    localparam int CW = BW * NB;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cipher_collector_if #(.BLOCK_W(BW), .NB_BLOCKS(NB), .TAG_W(TW)) bus ();

    cipher_collector #(.BLOCK_W(BW), .NB_BLOCKS(NB), .TAG_W(TW)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    typedef struct {
        int n;
        bit simul;
        int exp_count;
        bit exp_error;
    } vec_t;

    vec_t           tbl [7];
    logic [BW-1:0]  blk [5];
    int             errors = 0;
    int             checks = 0;

    task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.start_i        = 1'b0;
        bus.cipher_valid_i = 1'b0;
        bus.cipher_i       = '0;
        bus.tag_valid_i    = 1'b0;
        bus.tag_i          = '0;
        bus.ready_i        = 1'b0;
    endtask

    task automatic do_start();
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
    endtask

    task automatic send_block(input logic [BW-1:0] d, input bit with_tag, input logic [TW-1:0] t);
        bus.cipher_valid_i = 1'b1;
        bus.cipher_i       = d;
        if (with_tag) begin
            bus.tag_valid_i = 1'b1;
            bus.tag_i       = t;
        end
        step();
        bus.cipher_valid_i = 1'b0;
        bus.tag_valid_i    = 1'b0;
    endtask

    task automatic send_tag(input logic [TW-1:0] t);
        bus.tag_valid_i = 1'b1;
        bus.tag_i       = t;
        step();
        bus.tag_valid_i = 1'b0;
    endtask

    // n blocks from blk[]; with simul the last block travels with the tag.
    task automatic run_msg(input int n, input bit simul, input int gap, input logic [TW-1:0] t, input bit do_st);
        if (do_st) do_start();
        for (int k = 0; k < n; k++) begin
            send_block(blk[k], simul && (k == n-1), t);
            if (!(simul && (k == n-1))) repeat (gap) step();
        end
        if (!(simul && n > 0)) send_tag(t);
    endtask

    // Reference: the first NB blocks land in order from the MSB end, the rest are zero.
    function automatic logic [CW-1:0] exp_cipher(input int n);
        logic [CW-1:0] e;
        e = '0;
        for (int k = 0; k < NB; k++)
            e = (e << BW) | CW'((k < n) ? blk[k] : {BW{1'b0}});
        return e;
    endfunction

    task automatic check_result(input string nm, input int n, input logic [TW-1:0] t,
                                input int exp_cnt, input bit exp_err);
        chk({nm, " valid"},  CW'(bus.valid_o), CW'(1));
        chk({nm, " busy"},   CW'(bus.busy_o),  CW'(0));
        chk({nm, " cipher"}, bus.cipher_o,     exp_cipher(n));
        chk({nm, " tag"},    CW'(bus.tag_o),   CW'(t));
        chk({nm, " count"},  CW'(bus.count_o), CW'(exp_cnt));
        chk({nm, " error"},  CW'(bus.error_o), CW'(exp_err));
    endtask

    task automatic consume(input string nm);
        bus.ready_i = 1'b1;
        step();
        bus.ready_i = 1'b0;
        chk({nm, " valid after ready"}, CW'(bus.valid_o), CW'(0));
        chk({nm, " busy after ready"},  CW'(bus.busy_o),  CW'(0));
    endtask

    task automatic fixed_blocks();
        for (int k = 0; k < 4; k++) blk[k] = {16{4'(k + 1)}};
        blk[4] = '1;
    endtask

    initial begin : main
        logic [TW-1:0] t;
        logic [CW-1:0] held;
        bit            in_collect;
        int            n, gap, d, junk;
        bit            simul;

        tbl[0] = '{n: 4, simul: 1'b0, exp_count: 4, exp_error: 1'b0};
        tbl[1] = '{n: 2, simul: 1'b0, exp_count: 2, exp_error: 1'b1};
        tbl[2] = '{n: 5, simul: 1'b0, exp_count: 4, exp_error: 1'b1};
        tbl[3] = '{n: 4, simul: 1'b1, exp_count: 4, exp_error: 1'b0};
        tbl[4] = '{n: 3, simul: 1'b1, exp_count: 3, exp_error: 1'b1};
        tbl[5] = '{n: 0, simul: 1'b0, exp_count: 0, exp_error: 1'b1};
        tbl[6] = '{n: 1, simul: 1'b0, exp_count: 1, exp_error: 1'b1};

        clear_in();
        rst = 1'b1;
        step();
        step();
        chk("reset cipher", bus.cipher_o,        '0);
        chk("reset tag",    CW'(bus.tag_o),      '0);
        chk("reset count",  CW'(bus.count_o),    '0);
        chk("reset valid",  CW'(bus.valid_o),    '0);
        chk("reset busy",   CW'(bus.busy_o),     '0);
        chk("reset error",  CW'(bus.error_o),    '0);
        rst = 1'b0;
        step();

        // Stray strobe while idle
        fixed_blocks();
        send_block(blk[0], 1'b0, '0);
        chk("idle strobe error", CW'(bus.error_o), CW'(1));
        chk("idle strobe count", CW'(bus.count_o), CW'(0));
        chk("idle strobe valid", CW'(bus.valid_o), CW'(0));
        do_start();
        chk("start busy",  CW'(bus.busy_o),  CW'(1));
        chk("start error", CW'(bus.error_o), CW'(0));

        // Nominal message plus 5-cycle stall on ready
        t = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
        run_msg(4, 1'b0, 2, t, 1'b0);
        check_result("nominal", 4, t, 4, 1'b0);
        chk("nominal cipher literal", bus.cipher_o,
            {{16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}});
        held = bus.cipher_o;
        repeat (5) step();
        chk("stall valid",  CW'(bus.valid_o), CW'(1));
        chk("stall cipher", bus.cipher_o,     held);
        chk("stall tag",    CW'(bus.tag_o),   CW'(t));
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        chk("start without ready ignored", CW'(bus.valid_o), CW'(1));
        consume("nominal");

        // Table of message shapes
        for (int i = 0; i < 7; i++) begin
            fixed_blocks();
            t = {32'hA5A5_0000 + 32'(i), 96'h1234_5678_9ABC_DEF0_0F0F_F0F0};
            run_msg(tbl[i].n, tbl[i].simul, 1, t, 1'b1);
            check_result($sformatf("vec%0d", i), tbl[i].n, t, tbl[i].exp_count, tbl[i].exp_error);
            consume($sformatf("vec%0d", i));
        end

        // Back-to-back: ready and start together restart collection directly
        fixed_blocks();
        t = 128'h0BAD_CAFE_0000_1111_2222_3333_4444_5555;
        run_msg(4, 1'b1, 0, t, 1'b1);
        check_result("b2b first", 4, t, 4, 1'b0);
        bus.ready_i = 1'b1;
        bus.start_i = 1'b1;
        step();
        clear_in();
        chk("b2b busy",   CW'(bus.busy_o),  CW'(1));
        chk("b2b valid",  CW'(bus.valid_o), CW'(0));
        chk("b2b count",  CW'(bus.count_o), CW'(0));
        chk("b2b cipher", bus.cipher_o,     '0);
        for (int k = 0; k < 4; k++) blk[k] = {$urandom, $urandom};
        run_msg(4, 1'b0, 0, ~t, 1'b0);
        check_result("b2b second", 4, ~t, 4, 1'b0);
        consume("b2b second");

        // Asynchronous reset between clock edges mid-message
        fixed_blocks();
        do_start();
        send_block(blk[0], 1'b0, '0);
        send_block(blk[1], 1'b0, '0);
        #2 rst = 1'b1;
        #1;
        chk("async rst cipher", bus.cipher_o,     '0);
        chk("async rst count",  CW'(bus.count_o), '0);
        chk("async rst busy",   CW'(bus.busy_o),  '0);
        chk("async rst error",  CW'(bus.error_o), '0);
        #2 rst = 1'b0;
        step();
        for (int k = 0; k < 4; k++) blk[k] = {$urandom, $urandom};
        t = {$urandom, $urandom, $urandom, $urandom};
        run_msg(4, 1'b0, 1, t, 1'b1);
        check_result("after rst", 4, t, 4, 1'b0);
        consume("after rst");

        // Randomized messages against the reference rules
        in_collect = 1'b0;
        for (int it = 0; it < 40; it++) begin
            n     = $urandom_range(0, 5);
            simul = (n >= 1 && n <= 4) ? 1'($urandom_range(0, 1)) : 1'b0;
            gap   = $urandom_range(0, 2);
            t     = {$urandom, $urandom, $urandom, $urandom};
            if (!in_collect) do_start();
            in_collect = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                junk = $urandom_range(0, 4);
                for (int k = 0; k < junk; k++) send_block({$urandom, $urandom}, 1'b0, '0);
                do_start();
            end
            for (int k = 0; k < 5; k++) blk[k] = {$urandom, $urandom};
            run_msg(n, simul, gap, t, 1'b0);
            check_result($sformatf("rnd%0d", it), n, t, (n < NB) ? n : NB, n != NB);
            held = bus.cipher_o;
            d = $urandom_range(0, 3);
            repeat (d) step();
            chk($sformatf("rnd%0d held valid", it),  CW'(bus.valid_o), CW'(1));
            chk($sformatf("rnd%0d held cipher", it), bus.cipher_o,     held);
            if ($urandom_range(0, 1) == 1) begin
                bus.ready_i = 1'b1;
                bus.start_i = 1'b1;
                step();
                clear_in();
                chk($sformatf("rnd%0d b2b count", it),  CW'(bus.count_o), CW'(0));
                chk($sformatf("rnd%0d b2b cipher", it), bus.cipher_o,     '0);
                chk($sformatf("rnd%0d b2b busy", it),   CW'(bus.busy_o),  CW'(1));
                in_collect = 1'b1;
            end else begin
                consume($sformatf("rnd%0d", it));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
